// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm_pkg: shared encodings for the multi-cycle MIPS control FSM
package mc_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_RALU, C_SHIFT, C_IMM, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILL
    } iclass_t;

    localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_RS = 2'b11;
    localparam logic [1:0] A_PC = 2'b00, A_RS = 2'b01, A_RT = 2'b10;
    localparam logic [1:0] B_RT = 2'b00, B_FOUR = 2'b01, B_IMM = 2'b10, B_IMM_SL2 = 2'b11;
    localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
    localparam logic [1:0] DR_ALUOUT = 2'b00, DR_MDR = 2'b01, DR_PC = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ORI = 6'h0D,
                           OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR = 6'h08,
                           FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
                           FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

    localparam int ALUOP_W = 5;
    localparam logic [ALUOP_W-1:0] ALUOP_NOP = 5'd0, ALUOP_ADD = 5'd1, ALUOP_SUB = 5'd2,
                                   ALUOP_ADDU = 5'd3, ALUOP_SUBU = 5'd4, ALUOP_AND = 5'd5,
                                   ALUOP_OR = 5'd6, ALUOP_SLT = 5'd7, ALUOP_SLL = 5'd8,
                                   ALUOP_SRL = 5'd9, ALUOP_SRA = 5'd10, ALUOP_LUI = 5'd11,
                                   ALUOP_EQL = 5'd12;

    localparam logic [1:0] TRAP_NONE = 2'b00, TRAP_ILLEGAL = 2'b01, TRAP_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: instruction, memory handshake and datapath control bundle
interface mc_ctrl_fsm_if #(parameter int ALU_CTRL_W = 5);
    logic [5:0] opcode;
    logic [5:0] func;
    logic alu_zero;
    logic mem_ready;
    logic mem_req;
    logic mem_we;
    logic i_or_d;
    logic ir_write;
    logic pc_write;
    logic pc_write_cond;
    logic branch_ne;
    logic [1:0] pc_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic ext_op;
    logic reg_write;
    logic [1:0] reg_dst;
    logic [1:0] data_to_reg;
    logic instr_done;
    logic trap;
    logic [1:0] trap_cause;
    logic [2:0] state_o;

    modport master (
        input  opcode, func, alu_zero, mem_ready,
        output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne,
               pc_sel, alu_src_a, alu_src_b, alu_ctrl, ext_op, reg_write, reg_dst,
               data_to_reg, instr_done, trap, trap_cause, state_o
    );

    modport slave (
        output opcode, func, alu_zero, mem_ready,
        input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne,
               pc_sel, alu_src_a, alu_src_b, alu_ctrl, ext_op, reg_write, reg_dst,
               data_to_reg, instr_done, trap, trap_cause, state_o
    );
endinterface

// File: rtl/mc_ctrl_fsm_alu_decode.sv
// mc_alu_decode: opcode/func to ALU operation, extension mode and instruction class
module mc_alu_decode
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               ext_op,
    output iclass_t            iclass,
    output logic               illegal
);

    // classify the instruction; anything unrecognised stays C_ILL
    always_comb begin
        alu_op = ALUOP_ADD;
        ext_op = 1'b0;
        iclass = C_ILL;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_ADD:  begin alu_op = ALUOP_ADD;  iclass = C_RALU;  end
                    FN_ADDU: begin alu_op = ALUOP_ADDU; iclass = C_RALU;  end
                    FN_SUB:  begin alu_op = ALUOP_SUB;  iclass = C_RALU;  end
                    FN_SUBU: begin alu_op = ALUOP_SUBU; iclass = C_RALU;  end
                    FN_SLT:  begin alu_op = ALUOP_SLT;  iclass = C_RALU;  end
                    FN_AND:  begin alu_op = ALUOP_AND;  iclass = C_RALU;  end
                    FN_OR:   begin alu_op = ALUOP_OR;   iclass = C_RALU;  end
                    FN_SLL:  begin alu_op = ALUOP_SLL;  iclass = C_SHIFT; end
                    FN_SRL:  begin alu_op = ALUOP_SRL;  iclass = C_SHIFT; end
                    FN_SRA:  begin alu_op = ALUOP_SRA;  iclass = C_SHIFT; end
                    FN_JR:   iclass = C_JR;
                    default: iclass = C_ILL;
                endcase
            end
            OP_J:    iclass = C_J;
            OP_JAL:  iclass = C_JAL;
            OP_BEQ:  begin alu_op = ALUOP_EQL; iclass = C_BEQ; end
            OP_BNE:  begin alu_op = ALUOP_EQL; iclass = C_BNE; end
            OP_ADDI: begin alu_op = ALUOP_ADD; ext_op = 1'b1; iclass = C_IMM; end
            OP_SLTI: begin alu_op = ALUOP_SLT; ext_op = 1'b1; iclass = C_IMM; end
            OP_ORI:  begin alu_op = ALUOP_OR;  iclass = C_IMM; end
            OP_LUI:  begin alu_op = ALUOP_LUI; iclass = C_IMM; end
            OP_LW:   begin alu_op = ALUOP_ADD; ext_op = 1'b1; iclass = C_LW; end
            OP_SW:   begin alu_op = ALUOP_ADD; ext_op = 1'b1; iclass = C_SW; end
            default: iclass = C_ILL;
        endcase
        illegal = (iclass == C_ILL);
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control sequencer with memory timeout and illegal-op trap
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int ALU_CTRL_W  = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 8
) (
    input logic            clk,
    input logic            rst,
    mc_ctrl_fsm_if.master  bus
);

    state_t             state_q, state_d;
    iclass_t            cls_q, cls_d, dec_cls;
    logic [ALUOP_W-1:0] aop_q, aop_d, dec_aop, aop;
    logic               ext_q, ext_d, dec_ext, dec_ill;
    logic [TO_W-1:0]    wait_q, wait_d;
    logic               trap_q, trap_d;
    logic [1:0]         cause_q, cause_d;
    logic               waiting, timeout, jmp, br;

    mc_alu_decode u_dec (
        .opcode (bus.opcode),
        .func   (bus.func),
        .alu_op (dec_aop),
        .ext_op (dec_ext),
        .iclass (dec_cls),
        .illegal(dec_ill)
    );

    // state, latched instruction class and trap status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            cls_q   <= C_RALU;
            aop_q   <= ALUOP_NOP;
            ext_q   <= 1'b0;
            wait_q  <= '0;
            trap_q  <= 1'b0;
            cause_q <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            aop_q   <= aop_d;
            ext_q   <= ext_d;
            wait_q  <= wait_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    // next state; the trap fires on the MEM_TIMEOUT-th consecutive not-ready cycle
    always_comb begin
        waiting = (state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready;
        timeout = waiting && (wait_q == TO_W'(MEM_TIMEOUT - 1));
        wait_d  = waiting ? wait_q + 1'b1 : '0;
        cls_d   = cls_q;
        aop_d   = aop_q;
        ext_d   = ext_q;
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = timeout ? S_TRAP : bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                cls_d   = dec_cls;
                aop_d   = dec_aop;
                ext_d   = dec_ext;
                state_d = dec_ill ? S_TRAP : (dec_cls inside {C_J, C_JAL}) ? S_FETCH : S_EXEC;
            end
            S_EXEC:   state_d = (cls_q inside {C_BEQ, C_BNE, C_JR}) ? S_FETCH :
                                (cls_q inside {C_LW, C_SW}) ? S_MEM : S_WB;
            S_MEM:    state_d = timeout ? S_TRAP : !bus.mem_ready ? S_MEM :
                                (cls_q == C_LW) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_TRAP;
        endcase
        trap_d  = trap_q || (state_d == S_TRAP);
        cause_d = timeout ? TRAP_TIMEOUT :
                  (state_q == S_DECODE && dec_ill) ? TRAP_ILLEGAL : cause_q;
    end

    // Moore control decode, forced idle while reset is held so nothing writes on the reset edge
    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.pc_sel        = PC_ALU;
        bus.alu_src_a     = A_PC;
        bus.alu_src_b     = B_RT;
        bus.ext_op        = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = RD_RT;
        bus.data_to_reg   = DR_ALUOUT;
        bus.instr_done    = 1'b0;
        aop               = ALUOP_NOP;
        jmp               = 1'b0;
        br                = 1'b0;
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                    bus.alu_src_b = B_FOUR;
                    aop           = ALUOP_ADDU;
                end
                S_DECODE: begin
                    jmp             = dec_cls inside {C_J, C_JAL};
                    bus.alu_src_b   = B_IMM_SL2;
                    bus.ext_op      = 1'b1;
                    aop             = ALUOP_ADD;
                    bus.pc_write    = jmp;
                    bus.instr_done  = jmp;
                    bus.pc_sel      = jmp ? PC_JUMP : PC_ALU;
                    bus.reg_write   = (dec_cls == C_JAL);
                    bus.reg_dst     = (dec_cls == C_JAL) ? RD_RA : RD_RT;
                    bus.data_to_reg = (dec_cls == C_JAL) ? DR_PC : DR_ALUOUT;
                end
                S_EXEC: begin
                    br                = cls_q inside {C_BEQ, C_BNE};
                    jmp               = (cls_q == C_JR);
                    bus.alu_src_a     = (cls_q == C_SHIFT) ? A_RT : A_RS;
                    bus.alu_src_b     = (br || cls_q == C_RALU) ? B_RT : B_IMM;
                    bus.ext_op        = ext_q;
                    aop               = aop_q;
                    bus.pc_write_cond = br;
                    bus.branch_ne     = (cls_q == C_BNE);
                    bus.pc_write      = jmp;
                    bus.pc_sel        = jmp ? PC_RS : br ? PC_ALUOUT : PC_ALU;
                    bus.instr_done    = br || jmp;
                end
                S_MEM: begin
                    bus.mem_req    = 1'b1;
                    bus.i_or_d     = 1'b1;
                    bus.mem_we     = (cls_q == C_SW);
                    bus.instr_done = (cls_q == C_SW) && bus.mem_ready;
                end
                S_WB: begin
                    bus.reg_write   = 1'b1;
                    bus.instr_done  = 1'b1;
                    bus.reg_dst     = (cls_q inside {C_RALU, C_SHIFT}) ? RD_RD : RD_RT;
                    bus.data_to_reg = (cls_q == C_LW) ? DR_MDR : DR_ALUOUT;
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_ctrl   = ALU_CTRL_W'(aop);
    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;
    assign bus.state_o    = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: scoreboard bench for the multi-cycle control FSM
module tb_mc_ctrl_fsm;
    import mc_ctrl_fsm_pkg::*;

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, iod, irw, pcw, pcc, bne;
        logic [1:0] psel, srca, srcb;
        logic [4:0] alu;
        logic       ext, rw;
        logic [1:0] rdst, dtr;
        logic       done, trap;
        logic [1:0] cause;
    } obs_t;

    typedef struct {
        obs_t v;
        obs_t m;
    } exp_t;

    typedef struct {
        string n;
        obs_t  v;
        obs_t  m;
    } sb_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    sb_t  sb[$];

    mc_ctrl_fsm_if #(.ALU_CTRL_W(5)) bus ();

    mc_ctrl_fsm #(.ALU_CTRL_W(5), .MEM_TIMEOUT(15), .TO_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // enables are always checked; mux selects only where the state defines them
    function automatic exp_t e_base(input logic [2:0] st);
        exp_t e;
        e.v      = '0;
        e.v.st   = st;
        e.m      = '1;
        e.m.psel = '0;
        e.m.srca = '0;
        e.m.srcb = '0;
        e.m.alu  = '0;
        e.m.ext  = '0;
        e.m.rdst = '0;
        e.m.dtr  = '0;
        return e;
    endfunction

    function automatic exp_t e_reset();
        exp_t e;
        e.v = '0;
        e.m = '1;
        return e;
    endfunction

    function automatic exp_t e_fetch(input logic rdy);
        exp_t e = e_base(3'd0);
        e.v.req = 1'b1;
        e.v.irw = rdy;
        e.v.pcw = rdy;
        if (rdy) begin
            e.v.srcb = 2'b01;
            e.v.alu  = ALUOP_ADDU;
            e.m.psel = '1;
            e.m.srca = '1;
            e.m.srcb = '1;
            e.m.alu  = '1;
        end
        return e;
    endfunction

    function automatic exp_t e_decode();
        exp_t e = e_base(3'd1);
        e.v.srcb = 2'b11;
        e.v.ext  = 1'b1;
        e.v.alu  = ALUOP_ADD;
        e.m.srca = '1;
        e.m.srcb = '1;
        e.m.ext  = '1;
        e.m.alu  = '1;
        return e;
    endfunction

    function automatic exp_t e_exec(input logic [1:0] a, input logic [1:0] b, input logic ext, input logic [4:0] alu);
        exp_t e = e_base(3'd2);
        e.v.srca = a;
        e.v.srcb = b;
        e.v.ext  = ext;
        e.v.alu  = alu;
        e.m.srca = '1;
        e.m.srcb = '1;
        e.m.ext  = '1;
        e.m.alu  = '1;
        return e;
    endfunction

    function automatic exp_t e_mem(input logic we, input logic done);
        exp_t e = e_base(3'd3);
        e.v.req  = 1'b1;
        e.v.iod  = 1'b1;
        e.v.we   = we;
        e.v.done = done;
        return e;
    endfunction

    function automatic exp_t e_wb(input logic [1:0] rdst, input logic [1:0] dtr);
        exp_t e = e_base(3'd4);
        e.v.rw   = 1'b1;
        e.v.done = 1'b1;
        e.v.rdst = rdst;
        e.v.dtr  = dtr;
        e.m.rdst = '1;
        e.m.dtr  = '1;
        return e;
    endfunction

    function automatic exp_t e_trap(input logic [1:0] cause);
        exp_t e = e_base(3'd7);
        e.v.trap  = 1'b1;
        e.v.cause = cause;
        return e;
    endfunction

    task automatic ir(input logic [5:0] op, input logic [5:0] fn);
        bus.opcode = op;
        bus.func   = fn;
    endtask

    // one clock cycle: drive mem_ready, queue what the DUT must show this cycle
    task automatic step(input string n, input logic rdy, input exp_t e);
        bus.mem_ready = rdy;
        sb.push_back('{n, e.v, e.m});
        @(posedge clk);
        #1;
    endtask

    // monitor: compares the DUT outputs mid-cycle against the oldest queued expectation
    always @(negedge clk) begin : monitor
        obs_t act;
        sb_t  s;
        if (sb.size() > 0) begin
            s = sb.pop_front();
            act = '{st: bus.state_o, req: bus.mem_req, we: bus.mem_we, iod: bus.i_or_d,
                    irw: bus.ir_write, pcw: bus.pc_write, pcc: bus.pc_write_cond,
                    bne: bus.branch_ne, psel: bus.pc_sel, srca: bus.alu_src_a,
                    srcb: bus.alu_src_b, alu: bus.alu_ctrl, ext: bus.ext_op,
                    rw: bus.reg_write, rdst: bus.reg_dst, dtr: bus.data_to_reg,
                    done: bus.instr_done, trap: bus.trap, cause: bus.trap_cause};
            checks++;
            if (((act ^ s.v) & s.m) != '0) begin
                failures++;
                $display("FAIL %s: got %h expected %h (care mask %h)", s.n, act, s.v & s.m, s.m);
            end
        end
    end

    initial begin
        exp_t e;
        rst = 1'b0;
        bus.alu_zero  = 1'b0;
        bus.mem_ready = 1'b0;
        ir(6'h00, 6'h00);
        @(posedge clk);
        #1;
        step("reset", 1'b1, e_reset());
        rst = 1'b1;

        ir(6'h23, 6'h00);
        step("lw_fetch", 1'b1, e_fetch(1'b1));
        step("lw_decode", 1'b1, e_decode());
        step("lw_exec", 1'b1, e_exec(2'b01, 2'b10, 1'b1, ALUOP_ADD));
        step("lw_mem", 1'b1, e_mem(1'b0, 1'b0));
        step("lw_wb", 1'b1, e_wb(2'b00, 2'b01));

        bus.alu_zero = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ir(k == 0 ? 6'h04 : 6'h05, 6'h00);
            step("br_fetch", 1'b1, e_fetch(1'b1));
            step("br_decode", 1'b1, e_decode());
            e = e_exec(2'b01, 2'b00, 1'b0, ALUOP_EQL);
            e.m.ext  = '0;
            e.v.pcc  = 1'b1;
            e.v.bne  = (k == 1);
            e.v.psel = 2'b01;
            e.m.psel = '1;
            e.v.done = 1'b1;
            step(k == 0 ? "beq_exec" : "bne_exec", 1'b1, e);
        end
        bus.alu_zero = 1'b0;

        ir(6'h03, 6'h00);
        step("jal_fetch", 1'b1, e_fetch(1'b1));
        e = e_decode();
        e.v.pcw  = 1'b1;
        e.v.psel = 2'b10;
        e.m.psel = '1;
        e.v.rw   = 1'b1;
        e.v.rdst = 2'b10;
        e.m.rdst = '1;
        e.v.dtr  = 2'b10;
        e.m.dtr  = '1;
        e.v.done = 1'b1;
        step("jal_decode", 1'b1, e);

        ir(6'h00, 6'h08);
        step("jr_fetch", 1'b1, e_fetch(1'b1));
        step("jr_decode", 1'b1, e_decode());
        e = e_base(3'd2);
        e.v.pcw  = 1'b1;
        e.v.psel = 2'b11;
        e.m.psel = '1;
        e.v.done = 1'b1;
        step("jr_exec", 1'b1, e);

        ir(6'h00, 6'h03);
        step("sra_fetch", 1'b1, e_fetch(1'b1));
        step("sra_decode", 1'b1, e_decode());
        step("sra_exec", 1'b1, e_exec(2'b10, 2'b10, 1'b0, ALUOP_SRA));
        step("sra_wb", 1'b1, e_wb(2'b01, 2'b00));

        ir(6'h00, 6'h20);
        step("add_fetch", 1'b1, e_fetch(1'b1));
        step("add_decode", 1'b1, e_decode());
        e = e_exec(2'b01, 2'b00, 1'b0, ALUOP_ADD);
        e.m.ext = '0;
        step("add_exec", 1'b1, e);
        step("add_wb", 1'b1, e_wb(2'b01, 2'b00));

        ir(6'h0D, 6'h00);
        step("ori_fetch", 1'b1, e_fetch(1'b1));
        step("ori_decode", 1'b1, e_decode());
        step("ori_exec", 1'b1, e_exec(2'b01, 2'b10, 1'b0, ALUOP_OR));
        step("ori_wb", 1'b1, e_wb(2'b00, 2'b00));

        ir(6'h2B, 6'h00);
        step("sw_fetch", 1'b1, e_fetch(1'b1));
        step("sw_decode", 1'b1, e_decode());
        step("sw_exec", 1'b1, e_exec(2'b01, 2'b10, 1'b1, ALUOP_ADD));
        for (int k = 0; k < 3; k++) step("sw_mem_wait", 1'b0, e_mem(1'b1, 1'b0));
        step("sw_mem_done", 1'b1, e_mem(1'b1, 1'b1));

        ir(6'h02, 6'h00);
        for (int k = 0; k < 13; k++) step("slow_fetch_wait", 1'b0, e_fetch(1'b0));
        step("slow_fetch_ready14", 1'b1, e_fetch(1'b1));
        e = e_decode();
        e.v.pcw  = 1'b1;
        e.v.psel = 2'b10;
        e.m.psel = '1;
        e.v.done = 1'b1;
        step("j_decode", 1'b1, e);

        ir(6'h00, 6'h3F);
        step("badfn_fetch", 1'b1, e_fetch(1'b1));
        step("badfn_decode", 1'b1, e_decode());
        step("badfn_trap", 1'b1, e_trap(2'b01));
        step("badfn_trap_hold", 1'b0, e_trap(2'b01));
        rst = 1'b0;
        step("reset_from_trap", 1'b1, e_reset());
        rst = 1'b1;

        for (int k = 0; k < 15; k++) step("timeout_fetch_wait", 1'b0, e_fetch(1'b0));
        step("timeout_trap", 1'b0, e_trap(2'b10));
        step("timeout_trap_hold", 1'b1, e_trap(2'b10));
        rst = 1'b0;
        step("reset_from_timeout", 1'b0, e_reset());
        rst = 1'b1;

        ir(6'h23, 6'h00);
        step("abort_fetch", 1'b1, e_fetch(1'b1));
        step("abort_decode", 1'b1, e_decode());
        step("abort_exec", 1'b1, e_exec(2'b01, 2'b10, 1'b1, ALUOP_ADD));
        step("abort_mem_wait", 1'b0, e_mem(1'b0, 1'b0));
        rst = 1'b0;
        step("abort_async_reset", 1'b1, e_reset());
        rst = 1'b1;

        ir(6'h3F, 6'h00);
        step("badop_fetch", 1'b1, e_fetch(1'b1));
        step("badop_decode", 1'b1, e_decode());
        for (int k = 0; k < 20; k++) step("badop_trap_idle", k[0], e_trap(2'b01));

        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle successor to the single-cycle opcode/func decoder. It sequences each MIPS instruction through FETCH/DECODE/EXEC/MEM/WB and drives per-state datapath controls. It waits on a memory ready handshake with a bounded timeout and traps illegal instructions. It sits between the instruction register and the shared multi-cycle datapath (PC, IR, regfile, ALU, ALUOut, MDR).

Parameters:
ALU_CTRL_W, 5, width of alu_ctrl; ALUOp_* codes from the shared package, zero-extended to this width.
MEM_TIMEOUT, 15, max consecutive cycles waiting on mem_ready before trap; 1..255.
TO_W, 8, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
func  in  6  IR[5:0]
alu_zero  in  1  ALU equal flag from EXEC compare
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request (fetch or data)
mem_we  out  1  write strobe, valid with mem_req
i_or_d  out  1  0 = address from PC, 1 = address from ALUOut
ir_write  out  1  load IR
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if branch condition holds
branch_ne  out  1  condition is !alu_zero (bne) instead of alu_zero (beq)
pc_sel  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 rs
alu_src_a  out  2  00 PC, 01 rs, 10 rt (shifts)
alu_src_b  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
alu_ctrl  out  ALU_CTRL_W  ALU operation
ext_op  out  1  0 zero-extend, 1 sign-extend
reg_write  out  1  regfile write enable
reg_dst  out  2  00 rt, 01 rd, 10 $31
data_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC (link)
instr_done  out  1  one-cycle pulse in the last cycle of each instruction
trap  out  1  sticky; set on illegal instruction or memory timeout
trap_cause  out  2  01 illegal, 10 mem timeout, 00 none
state_o  out  3  current state, for debug

Behaviour:
- Reset (rst=0, async): state=FETCH. wait counter=0. trap=0, trap_cause=00. Every registered output is 0.
- Outputs are a Moore decode of state, plus registered opcode/func class. Exception: pc_write_cond gating is done in the datapath.
- FETCH: mem_req=1, i_or_d=0.
  - mem_ready=1: ir_write=1, pc_write=1, alu_src_a=PC, alu_src_b=4, alu_ctrl=ADDU, pc_sel=00; go to DECODE.
  - mem_ready=0: stay in FETCH with no IR/PC write.
- DECODE: alu_src_a=PC, alu_src_b=imm<<2, ext_op=1, alu_ctrl=ADD (ALUOut <= branch target).
  - j: pc_write=1, pc_sel=10, instr_done; go to FETCH.
  - jal: also reg_write=1, reg_dst=10, data_to_reg=10.
  - Unknown opcode, or R-type with unknown func: trap_cause=01; go to TRAP.
  - All other instructions: go to EXEC.
- EXEC:
  - R-ALU (add, sub, addu, subu, slt, and, or): a=rs, b=rt.
  - sll/srl/sra: a=rt, b=imm with ext_op=0 (ALU uses [10:6]).
  - addi, slti: b=imm, ext_op=1. ori: ext_op=0. lui: ext_op=0, alu_ctrl=LUI.
  - lw/sw: ADD with sign-extended imm.
  - beq/bne: a=rs, b=rt, alu_ctrl=EQL, pc_write_cond=1, branch_ne=(bne), pc_sel=01, instr_done; go to FETCH.
  - jr: pc_write=1, pc_sel=11, instr_done; go to FETCH.
  - lw/sw go to MEM; all others go to WB.
- MEM: mem_req=1, i_or_d=1, mem_we=(sw); hold until mem_ready.
  - sw: on mem_ready, instr_done; go to FETCH.
  - lw: on mem_ready (MDR latches); go to WB.
- WB: reg_write=1, instr_done; go to FETCH.
  - reg_dst=01 for R-type, 00 otherwise. data_to_reg=01 for lw, 00 otherwise.
- Timeout: the counter increments each FETCH/MEM cycle with mem_ready=0 and clears on mem_ready or on leaving the state.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0: trap_cause=10; go to TRAP. mem_req deasserts in TRAP.
- TRAP: absorbing. All enables 0, trap=1. Only reset exits.
- Zero-wait latencies: j/jal 2 cycles; beq/bne/jr 3; ALU ops and sw 4; lw 5.
- Reset mid-instruction: aborts immediately. No partial write may occur on the edge where rst asserts.
- mem_ready while mem_req=0: ignored.

Decomposition:
- Shared package (extend ctrl_encode_def / instruction_def):
  - State encodings FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
  - Mux select constants for pc_sel, alu_src_a/b, reg_dst, data_to_reg.
  - Opcode/funct codes for and, or, srl, sra, addi, jal, jr.
  - ALUOp_* codes and trap cause codes.
- One sub-module, mc_alu_decode: combinational opcode/func -> {alu_ctrl, ext_op, class, illegal}. The FSM consumes it.

Test Plan:
- Reset, then lw $t0,4($zero) with mem_ready=1 always -> states 0,1,2,3,4; instr_done in cycle 5; reg_dst=00, data_to_reg=01 in WB.
- beq with alu_zero=1, then bne with alu_zero=1 -> pc_write_cond=1 and pc_sel=01 in EXEC for both, branch_ne=0 then 1; each takes 3 cycles.
- jal 0x100 -> DECODE asserts pc_write, pc_sel=10, reg_write, reg_dst=10, data_to_reg=10; next state FETCH. Follow with jr $31 -> pc_sel=11 in EXEC.
- sra $t1,$t2,3 -> EXEC a=10, b=10, ext_op=0, alu_ctrl=SRA; WB reg_dst=01.
- Opcode 0x3F -> DECODE goes to TRAP; trap=1, trap_cause=01; outputs stay idle over 20 cycles despite mem_ready toggling.
- Fetch with mem_ready held 0 -> trap at MEM_TIMEOUT=15 wait cycles with cause 10. Repeat with mem_ready rising on wait cycle 14 -> no trap. Assert rst mid-MEM -> state 0 asynchronously, mem_req=0.
